// File: rtl/interval_timer_scheduler_pkg.sv
// ============================================================================
// interval_timer_pkg: shared register map, control bits and FSM encoding for
// the interval timer scheduler.  Rev 1.0
// ============================================================================
`default_nettype none

package interval_timer_pkg;

  localparam logic [2:0] TMR_STATUS   = 3'd0;
  localparam logic [2:0] TMR_CONTROL  = 3'd1;
  localparam logic [2:0] TMR_PERIOD_L = 3'd2;
  localparam logic [2:0] TMR_PERIOD_H = 3'd3;

  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;

  localparam logic [15:0] CTRL_STOP  = 16'(1) << STOP;
  // One-shot means CONT stays clear.
  localparam logic [15:0] CTRL_START = ((16'(1) << START) | (16'(1) << ITO)) & ~(16'(1) << CONT);

  typedef enum logic [2:0] {
    S_IDLE, S_STOP, S_WR_PL, S_WR_PH, S_START, S_WAIT_IRQ, S_CLEAR, S_FINISH
  } state_e;

  function automatic logic [31:0] clamp_load(input logic [31:0] period, input logic [31:0] min_period);
    return ((period < min_period) ? min_period : period) - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/interval_timer_scheduler_rr_arbiter.sv
// ============================================================================
// rr_arbiter: combinational round-robin pick of the first request at or after
// the pointer, wrapping.  Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDXW-1:0]    ptr_i,
  output logic               valid_o,
  output logic [IDXW-1:0]    idx_o
);

  int j;

  // Scan from farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = IDXW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/interval_timer_scheduler.sv
// ============================================================================
// interval_timer_scheduler: Avalon-MM master sharing one interval timer among
// NUM_REQ requesters as round-robin one-shot timeouts.  Rev 1.0
// ============================================================================
`default_nettype none

module interval_timer_scheduler
  import interval_timer_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MIN_PERIOD = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*32-1:0]  req_period,
  input  logic [NUM_REQ-1:0]     cancel,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     aborted,
  output logic                   busy,
  output logic [2:0]             tmr_address,
  output logic                   tmr_chipselect,
  output logic                   tmr_write_n,
  output logic [15:0]            tmr_writedata,
  input  logic                   tmr_irq
);

  localparam int IDXW = $clog2(NUM_REQ);

  state_e              state_q;
  logic [IDXW-1:0]     owner_q, rr_ptr_q;
  logic [31:0]         load_q, load_d;
  logic                abort_q, stop_sent_q;
  logic [NUM_REQ-1:0]  grant_q, done_q, aborted_q;
  logic                busy_q, cs_q, write_n_q;
  logic [2:0]          addr_q;
  logic [15:0]         wdata_q;
  logic                arb_valid;
  logic [IDXW-1:0]     arb_idx;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_arb (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .valid_o (arb_valid),
    .idx_o   (arb_idx)
  );

  assign load_d = clamp_load(req_period[{arb_idx, 5'b0} +: 32], 32'(MIN_PERIOD));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      load_q      <= '0;
      abort_q     <= 1'b0;
      stop_sent_q <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
      aborted_q   <= '0;
      busy_q      <= 1'b0;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      // Strobes and completion pulses last a single cycle.
      cs_q      <= 1'b0;
      write_n_q <= 1'b1;
      done_q    <= '0;
      aborted_q <= '0;
      case (state_q)
        S_IDLE: if (arb_valid) begin
          owner_q     <= arb_idx;
          grant_q     <= NUM_REQ'(1) << arb_idx;
          busy_q      <= 1'b1;
          load_q      <= load_d;
          abort_q     <= 1'b0;
          stop_sent_q <= 1'b0;
          state_q     <= S_STOP;
        end
        S_STOP: begin
          {cs_q, write_n_q, addr_q, wdata_q} <= {2'b10, TMR_CONTROL, CTRL_STOP};
          state_q <= S_WR_PL;
        end
        S_WR_PL: begin
          {cs_q, write_n_q, addr_q, wdata_q} <= {2'b10, TMR_PERIOD_L, load_q[15:0]};
          state_q <= S_WR_PH;
        end
        S_WR_PH: begin
          {cs_q, write_n_q, addr_q, wdata_q} <= {2'b10, TMR_PERIOD_H, load_q[31:16]};
          state_q <= S_START;
        end
        S_START: begin
          {cs_q, write_n_q, addr_q, wdata_q} <= {2'b10, TMR_CONTROL, CTRL_START};
          state_q <= S_WAIT_IRQ;
        end
        S_WAIT_IRQ: begin
          if (cancel[owner_q]) begin
            abort_q <= 1'b1;
            state_q <= S_CLEAR;
          end else if (tmr_irq) begin
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          // An aborted timer is still running, so halt it before clearing status.
          if (abort_q && !stop_sent_q) begin
            {cs_q, write_n_q, addr_q, wdata_q} <= {2'b10, TMR_CONTROL, CTRL_STOP};
            stop_sent_q <= 1'b1;
          end else begin
            {cs_q, write_n_q, addr_q, wdata_q} <= {2'b10, TMR_STATUS, 16'h0000};
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          done_q    <= abort_q ? '0 : grant_q;
          aborted_q <= abort_q ? grant_q : '0;
          grant_q   <= '0;
          busy_q    <= 1'b0;
          abort_q   <= 1'b0;
          rr_ptr_q  <= (owner_q == IDXW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant          = grant_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign busy           = busy_q;
  assign tmr_address    = addr_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = write_n_q;
  assign tmr_writedata  = wdata_q;

endmodule

`default_nettype wire
